// File: rtl/alu_pkg.sv
// Shared ALU opcode and sequencer state definitions for the serial ALU datapath.
package alu_pkg;

    // ALUOp: bit2 = BInvert, bits[1:0] = slice Operation
    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_serial_ctrl_alu_1bit.sv
// One-bit ALU slice: AND / OR / ADD / XOR with optional B inversion.
module ALU_1bit (
    input  logic       A,
    input  logic       B,
    input  logic       CIN,
    input  logic       BInvert,
    input  logic [1:0] Operation,
    output logic       Result,
    output logic       COUT
);

    logic b_eff;

    assign b_eff = B ^ BInvert;
    assign COUT  = (A & b_eff) | (A & CIN) | (b_eff & CIN);

    // Select the slice function from Operation
    always_comb begin
        Result = 1'b0;
        unique case (Operation)
            2'b00:   Result = A & b_eff;
            2'b01:   Result = A | b_eff;
            2'b10:   Result = A ^ b_eff ^ CIN;
            default: Result = A ^ b_eff;
        endcase
    end

endmodule

// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU sequencer: drives one ALU_1bit slice for WIDTH cycles, LSB first,
// and presents a registered result with Zero/CarryOut/Overflow flags.
module alu_serial_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             Clock,
    input  logic             ResetN,
    input  logic             Start,
    input  logic [2:0]       ALUOp,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Result,
    output logic             Zero,
    output logic             CarryOut,
    output logic             Overflow
);

    localparam int unsigned      CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0]    CNT_PEN  = CW'(WIDTH - 2);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [2:0]       op_q, op_d;
    logic             carry_q, carry_d;
    logic             cin_msb_q, cin_msb_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             zero_q, zero_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic             slice_res;
    logic             slice_cout;

    ALU_1bit u_slice (
        .A         (a_q[cnt_q]),
        .B         (b_q[cnt_q]),
        .CIN       (carry_q),
        .BInvert   (op_q[2]),
        .Operation (op_q[1:0]),
        .Result    (slice_res),
        .COUT      (slice_cout)
    );

    // State, datapath and output registers; reset clears everything immediately
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            carry_q   <= 1'b0;
            cin_msb_q <= 1'b0;
            sh_q      <= '0;
            res_q     <= '0;
            zero_q    <= 1'b0;
            cout_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            a_q       <= a_d;
            b_q       <= b_d;
            op_q      <= op_d;
            carry_q   <= carry_d;
            cin_msb_q <= cin_msb_d;
            sh_q      <= sh_d;
            res_q     <= res_d;
            zero_q    <= zero_d;
            cout_q    <= cout_d;
            ovf_q     <= ovf_d;
        end
    end

    // Next-state: accept in IDLE, shift one bit per RUN cycle, publish on entry to DONE
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        carry_d   = carry_q;
        cin_msb_d = cin_msb_q;
        sh_d      = sh_q;
        res_d     = res_q;
        zero_d    = zero_q;
        cout_d    = cout_q;
        ovf_d     = ovf_q;
        unique case (state_q)
            S_IDLE: begin
                if (Start) begin
                    a_d     = A;
                    b_d     = B;
                    op_d    = ALUOp;
                    carry_d = ALUOp[2];
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                sh_d    = {slice_res, sh_q[WIDTH-1:1]};
                carry_d = slice_cout;
                // Carry produced by bit WIDTH-2 is the carry into the MSB
                if (cnt_q == CNT_PEN) begin
                    cin_msb_d = slice_cout;
                end
                if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                    res_d   = sh_d;
                    zero_d  = (sh_d == '0);
                    if (op_q[1:0] == OP_ADD[1:0]) begin
                        cout_d = slice_cout;
                        ovf_d  = cin_msb_q ^ slice_cout;
                    end else begin
                        cout_d = 1'b0;
                        ovf_d  = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign Busy     = (state_q != S_IDLE);
    assign Done     = (state_q == S_DONE);
    assign Result   = res_q;
    assign Zero     = zero_q;
    assign CarryOut = cout_q;
    assign Overflow = ovf_q;

endmodule
